// File: rtl/prog_instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_instr_mem
// Purpose  : Loadable instruction memory for the MIPS datapath. A program is
//            streamed in as big-endian bytes over a valid/ready loader port.
//            In RUN the fetch port returns the addressed word one cycle after
//            the request. Words beyond the loaded count read as 0 (nop).
//            Misaligned and out-of-range fetches are flagged.
// Ports    : clk, reset (async, active-high)
//            load_start / load_done       - loader control pulses
//            ld_byte, ld_valid, ld_ready  - program byte stream
//            fetch_req, fetch_addr        - fetch request (byte address)
//            instr, instr_valid,
//            misalign, out_of_range       - registered fetch response
//            busy                         - high while loading
// Revision : 1.0 - initial release
// ============================================================================
module prog_instr_mem #(
  parameter int unsigned DEPTH   = 64,
  parameter logic [31:0] PC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        load_done,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign,
  output logic        out_of_range,
  output logic        busy
);

  // Write pointer must be able to hold DEPTH itself (the "full" value).
  localparam int unsigned c_WPW  = $clog2(DEPTH + 1);
  localparam int unsigned c_IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [c_WPW-1:0] c_FULL = c_WPW'(DEPTH);
  localparam logic [c_WPW-1:0] c_ONE  = c_WPW'(1);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;

  logic [1:0]       r_state;
  logic [c_WPW-1:0] r_wptr;
  logic [c_WPW-1:0] r_loaded;
  logic [1:0]       r_bcnt;
  logic [23:0]      r_asm;

  logic [31:0]      r_mem [0:DEPTH-1];

  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic             r_misalign;
  logic             r_out_of_range;

  logic             w_accept;
  logic             w_word_done;
  logic             w_we;
  logic [31:0]      w_idx32;
  logic [c_IDXW-1:0] w_idx;
  logic             w_mis;
  logic             w_oor;
  logic             w_hit;
  logic             w_fetch;
  logic [31:0]      w_rdata;

  // --------------------------------------------------------------------------
  // Loader handshake
  // --------------------------------------------------------------------------
  assign ld_ready    = (r_state == c_LOAD) && (r_wptr < c_FULL);
  assign busy        = (r_state == c_LOAD);
  assign w_accept    = ld_valid && ld_ready;
  assign w_word_done = w_accept && (r_bcnt == 2'd3);
  // A simultaneous load_start restarts the load, so the completing word is
  // not committed.
  assign w_we        = w_word_done && !load_start;

  // --------------------------------------------------------------------------
  // Fetch address decode
  // --------------------------------------------------------------------------
  // Subtraction wraps for addresses below PC_BASE; that case is caught by the
  // explicit below-base compare rather than by the index range check.
  assign w_idx32 = (fetch_addr - PC_BASE) >> 2;
  assign w_idx   = w_idx32[c_IDXW-1:0];
  assign w_mis   = (fetch_addr[1:0] != 2'b00);
  assign w_oor   = (fetch_addr < PC_BASE) || (w_idx32 >= 32'(DEPTH));
  assign w_hit   = !w_mis && !w_oor && (w_idx32 < 32'(r_loaded));
  assign w_fetch = fetch_req && (r_state == c_RUN);
  assign w_rdata = r_mem[w_idx];

  // --------------------------------------------------------------------------
  // Control state, pointers and byte assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_EMPTY;
      r_wptr   <= '0;
      r_loaded <= '0;
      r_bcnt   <= 2'd0;
      r_asm    <= 24'd0;
    end else if (load_start) begin
      r_state  <= c_LOAD;
      r_wptr   <= '0;
      r_loaded <= '0;
      r_bcnt   <= 2'd0;
    end else if (r_state == c_LOAD) begin
      if (w_accept) begin
        if (r_bcnt == 2'd3) begin
          r_wptr <= r_wptr + c_ONE;
          r_bcnt <= 2'd0;
        end else begin
          r_asm  <= {r_asm[15:0], ld_byte};
          r_bcnt <= r_bcnt + 2'd1;
        end
      end
      if (load_done) begin
        r_state  <= c_RUN;
        // A word completed on this same edge still counts as loaded; any
        // partial word is dropped.
        r_loaded <= w_word_done ? (r_wptr + c_ONE) : r_wptr;
        r_bcnt   <= 2'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: not reset, reads are gated by r_loaded
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wptr[c_IDXW-1:0]] <= {r_asm, ld_byte};
    end
  end

  // --------------------------------------------------------------------------
  // Registered fetch response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr        <= 32'd0;
      r_instr_valid  <= 1'b0;
      r_misalign     <= 1'b0;
      r_out_of_range <= 1'b0;
    end else if (w_fetch) begin
      r_instr        <= w_hit ? w_rdata : 32'd0;
      r_instr_valid  <= 1'b1;
      r_misalign     <= w_mis;
      r_out_of_range <= w_oor;
    end else begin
      r_instr        <= 32'd0;
      r_instr_valid  <= 1'b0;
      r_misalign     <= 1'b0;
      r_out_of_range <= 1'b0;
    end
  end

  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign misalign     = r_misalign;
  assign out_of_range = r_out_of_range;

endmodule
`default_nettype wire
